// File: rtl/buzzer_arbiter.sv
// rtl/buzzer_arbiter.sv - quiz buzzer arbiter with debounce, false-start lockout and timeout
module buzzer_arbiter #(
    parameter int          NUM_PLAYERS     = 4,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [15:0] TIMEOUT         = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PLAYERS-1:0] btn_n,
    input  logic                   arm,
    input  logic                   clear,
    output logic [1:0]             state,
    output logic [NUM_PLAYERS-1:0] pressed,
    output logic                   first_valid,
    output logic [2:0]             first_id,
    output logic [15:0]            react_time,
    output logic [NUM_PLAYERS-1:0] false_start,
    output logic                   timed_out
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    logic [NUM_PLAYERS-1:0] r_sync1;
    logic [NUM_PLAYERS-1:0] r_sync2;
    logic [NUM_PLAYERS-1:0] r_pressed;
    logic [NUM_PLAYERS-1:0] r_pressed_d;
    logic [CW-1:0]          r_cnt [NUM_PLAYERS];
    state_t                 r_state;
    logic [15:0]            r_timer;
    logic                   r_first_valid;
    logic [2:0]             r_first_id;
    logic [15:0]            r_react_time;
    logic [NUM_PLAYERS-1:0] r_false_start;
    logic                   r_timed_out;

    logic [NUM_PLAYERS-1:0] w_event;
    logic [NUM_PLAYERS-1:0] w_elig;
    logic                   w_any;
    logic [2:0]             w_win_id;

    // Two-flop synchronizer; inversion happens on entry so a cleared chain means "not pressed"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // Per-channel debounce: flip the level only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pressed <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (r_sync2[i] != r_pressed[i]) begin
                    if (r_cnt[i] == CNT_LAST) begin
                        r_pressed[i] <= r_sync2[i];
                        r_cnt[i]     <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Delayed copy of the debounced level, used to spot rising edges (press events)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pressed_d <= '0;
        end else begin
            r_pressed_d <= r_pressed;
        end
    end

    assign w_event = r_pressed & ~r_pressed_d;
    assign w_elig  = w_event & ~r_false_start;

    // Lowest eligible channel wins a same-cycle tie
    always_comb begin
        w_any    = 1'b0;
        w_win_id = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_any    = 1'b1;
                w_win_id = 3'(i);
            end
        end
    end

    // Round FSM with registered capture outputs; clear overrides everything else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_first_valid <= 1'b0;
            r_first_id    <= '0;
            r_react_time  <= '0;
            r_false_start <= '0;
            r_timed_out   <= 1'b0;
        end else if (clear) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_first_valid <= 1'b0;
            r_first_id    <= '0;
            r_react_time  <= '0;
            r_false_start <= '0;
            r_timed_out   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_false_start <= r_false_start | w_event;
                    if (arm) begin
                        r_state       <= S_ARMED;
                        r_timer       <= '0;
                        r_first_valid <= 1'b0;
                        r_first_id    <= '0;
                        r_react_time  <= '0;
                        r_timed_out   <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (w_any) begin
                        r_state       <= S_DONE;
                        r_first_valid <= 1'b1;
                        r_first_id    <= w_win_id;
                        r_react_time  <= r_timer;
                    end else if (r_timer == TIMEOUT) begin
                        r_state     <= S_DONE;
                        r_timed_out <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_DONE;
                end
            endcase
        end
    end

    assign state       = r_state;
    assign pressed     = r_pressed;
    assign first_valid = r_first_valid;
    assign first_id    = r_first_id;
    assign react_time  = r_react_time;
    assign false_start = r_false_start;
    assign timed_out   = r_timed_out;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb/tb_buzzer_arbiter.sv - scoreboard bench for buzzer_arbiter
module tb_buzzer_arbiter;
    localparam int          N  = 4;
    localparam int          DB = 4;
    localparam logic [15:0] TO = 16'd100;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic [N-1:0] btn_n = '1;
    logic         arm   = 1'b0;
    logic         clear = 1'b0;
    logic [1:0]   state;
    logic [N-1:0] pressed;
    logic         first_valid;
    logic [2:0]   first_id;
    logic [15:0]  react_time;
    logic [N-1:0] false_start;
    logic         timed_out;

    buzzer_arbiter #(.NUM_PLAYERS(N), .DEBOUNCE_CYCLES(DB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .arm(arm), .clear(clear),
        .state(state), .pressed(pressed), .first_valid(first_valid),
        .first_id(first_id), .react_time(react_time),
        .false_start(false_start), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        fv;
        logic [2:0]  fid;
        logic [15:0] rt;
        logic        to;
    } cap_t;
    cap_t sbq[$];

    // Reference model: button levels kept as sample histories, round as plain integers
    logic [N-1:0] rawq[$];
    logic [N-1:0] seenq[$];
    logic [N-1:0] m_p, m_pprev, m_fs;
    int m_state = 0, m_timer = 0, m_fid = 0, m_rt = 0;
    bit m_fv = 0, m_to = 0;

    task automatic m_reset();
        rawq = {};
        rawq.push_back('0);
        rawq.push_back('0);
        seenq = {};
        m_p = '0; m_pprev = '0; m_fs = '0;
        m_state = 0; m_timer = 0; m_fv = 0; m_fid = 0; m_rt = 0; m_to = 0;
    endtask

    always @(posedge clk) begin : model
        logic [N-1:0] ev, seen, elig;
        bit diff_all, found;
        if (rst) begin
            m_reset();
        end else begin
            ev = m_p & ~m_pprev;
            m_pprev = m_p;
            seen = rawq.pop_front();
            rawq.push_back(~btn_n);
            seenq.push_back(seen);
            if (seenq.size() > DB) void'(seenq.pop_front());
            if (seenq.size() == DB) begin
                for (int i = 0; i < N; i++) begin
                    diff_all = 1;
                    for (int k = 0; k < DB; k++) if (seenq[k][i] == m_p[i]) diff_all = 0;
                    if (diff_all) m_p[i] = seen[i];
                end
            end
            if (clear) begin
                m_state = 0; m_fs = '0; m_fv = 0; m_fid = 0; m_rt = 0; m_to = 0;
            end else if (m_state == 0) begin
                m_fs = m_fs | ev;
                if (arm) begin
                    m_state = 1; m_timer = 0; m_fv = 0; m_fid = 0; m_rt = 0; m_to = 0;
                end
            end else if (m_state == 1) begin
                elig = ev & ~m_fs;
                if (elig != 0) begin
                    found = 0;
                    for (int i = 0; i < N; i++) if (elig[i] && !found) begin m_fid = i; found = 1; end
                    m_fv = 1; m_rt = m_timer; m_state = 2;
                    sbq.push_back('{fv: 1'b1, fid: 3'(m_fid), rt: 16'(m_rt), to: 1'b0});
                end else if (m_timer == int'(TO)) begin
                    m_to = 1; m_state = 2;
                    sbq.push_back('{fv: 1'b0, fid: 3'd0, rt: 16'd0, to: 1'b1});
                end else begin
                    m_timer++;
                end
            end
        end
    end

    // Monitor: per-cycle level checks, capture checks on each entry to DONE
    int prev_state = 0;
    always @(posedge clk) begin : monitor
        cap_t e;
        #1;
        check("state", int'(state), m_state);
        check("pressed", int'(pressed), int'(m_p));
        check("false_start", int'(false_start), int'(m_fs));
        if (state == 2'd2 && prev_state != 2) begin
            if (sbq.size() == 0) begin
                check("sb_pending", sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                check("sb_first_valid", int'(first_valid), int'(e.fv));
                check("sb_first_id", int'(first_id), int'(e.fid));
                check("sb_react_time", int'(react_time), int'(e.rt));
                check("sb_timed_out", int'(timed_out), int'(e.to));
            end
        end
        prev_state = int'(state);
    end

    task automatic pulse_arm();
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n = 0;
        while (int'(state) != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(state), s);
    endtask

    task automatic settle();
        @(negedge clk) btn_n = '1;
        repeat (12) @(negedge clk);
        pulse_clear();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_valid"}, int'(first_valid), 0);
        check({tag, "_id"}, int'(first_id), 0);
        check({tag, "_react"}, int'(react_time), 0);
        check({tag, "_fs"}, int'(false_start), 0);
        check({tag, "_to"}, int'(timed_out), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        check("reset_pressed", int'(pressed), 0);
        rst = 1'b0;

        // Single winner, known reaction time
        pulse_arm();
        repeat (10) @(negedge clk);
        btn_n[2] = 1'b0;
        wait_state(2, 40, "win2_done");
        check("win2_id", int'(first_id), 2);
        check("win2_valid", int'(first_valid), 1);
        check("win2_react", int'(react_time), 16);
        settle();

        // Simultaneous presses -> lowest index
        pulse_arm();
        repeat (3) @(negedge clk);
        btn_n[1] = 1'b0;
        btn_n[3] = 1'b0;
        wait_state(2, 40, "tie_done");
        check("tie_id", int'(first_id), 1);
        settle();

        // False start lockout
        @(negedge clk) btn_n[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("fs_set", int'(false_start), 1);
        btn_n[0] = 1'b1;
        repeat (10) @(negedge clk);
        pulse_arm();
        check("fs_kept", int'(false_start), 1);
        btn_n[0] = 1'b0;
        repeat (12) @(negedge clk);
        check("lockout_armed", int'(state), 1);
        btn_n[3] = 1'b0;
        wait_state(2, 40, "lockout_done");
        check("lockout_id", int'(first_id), 3);
        settle();

        // Glitch rejection, then timeout, then DONE ignores arm and presses
        @(negedge clk) btn_n[0] = 1'b0;
        repeat (2) @(negedge clk);
        btn_n[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_pressed", int'(pressed), 0);
        check("glitch_fs", int'(false_start), 0);
        pulse_arm();
        btn_n[1] = 1'b0;
        repeat (2) @(negedge clk);
        btn_n[1] = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_armed", int'(state), 1);
        wait_state(2, 150, "timeout_done");
        check("timeout_to", int'(timed_out), 1);
        check("timeout_valid", int'(first_valid), 0);
        pulse_arm();
        btn_n[1] = 1'b0;
        repeat (12) @(negedge clk);
        check("done_hold_state", int'(state), 2);
        check("done_hold_to", int'(timed_out), 1);
        check("done_hold_valid", int'(first_valid), 0);
        settle();

        // Abort paths
        pulse_arm();
        repeat (5) @(negedge clk);
        pulse_clear();
        check_zero("clear_abort");
        pulse_arm();
        repeat (5) @(negedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_zero("rst_abort");
        @(negedge clk) begin arm = 1'b1; clear = 1'b1; end
        @(negedge clk) begin arm = 1'b0; clear = 1'b0; end
        check("clear_arm_state", int'(state), 0);

        // Button held through reset becomes a false start
        @(negedge clk) btn_n[2] = 1'b0;
        repeat (10) @(negedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (10) @(negedge clk);
        check("held_rst_fs", int'(false_start), 4);
        settle();

        // Randomized rounds
        for (int r = 0; r < 25; r++) begin
            pulse_clear();
            for (int c = 0; c < 160; c++) begin
                @(negedge clk);
                arm   = ($urandom_range(0, 19) == 0);
                clear = ($urandom_range(0, 199) == 0);
                rst   = ($urandom_range(0, 499) == 0);
                for (int i = 0; i < N; i++) if ($urandom_range(0, 11) == 0) btn_n[i] = ~btn_n[i];
            end
            @(negedge clk) begin arm = 1'b0; clear = 1'b0; rst = 1'b0; end
        end
        settle();
        repeat (2) @(negedge clk);
        check("sb_drain", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/buzzer_arbiter.md
BUZZER_ARBITER -- requirements
Module: buzzer_arbiter

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 4, legal range 2..8: number of player button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, minimum 2: consecutive stable cycles required before a debounced level changes.
REQ-003 SHALL have parameter TIMEOUT, default 16'hFFFF: ARMED cycles allowed before the round closes with no winner.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port btn_n, input, NUM_PLAYERS: raw active-low player buttons, asynchronous to clk.
REQ-007 SHALL have port arm, input, 1: single-cycle request to open a round.
REQ-008 SHALL have port clear, input, 1: single-cycle request to abandon or close a round.
REQ-009 SHALL have port state, output, 2: 0 = IDLE, 1 = ARMED, 2 = DONE.
REQ-010 SHALL have port pressed, output, NUM_PLAYERS: debounced active-high button levels.
REQ-011 SHALL have port first_valid, output, 1: a winner was captured.
REQ-012 SHALL have port first_id, output, 3: winning channel index.
REQ-013 SHALL have port react_time, output, 16: ARMED cycles elapsed at capture.
REQ-014 SHALL have port false_start, output, NUM_PLAYERS: players that pressed while IDLE.
REQ-015 SHALL have port timed_out, output, 1: the round closed with no winner.

Function
REQ-016 SHALL pass each btn_n bit through a 2-flop synchronizer and invert it to active-high.
REQ-017 SHALL keep one debounce counter per channel; pressed[i] changes only after the synchronized level differs from pressed[i] for DEBOUNCE_CYCLES consecutive cycles; any glitch resets the counter to 0.
REQ-018 SHALL define a press event for channel i as a 0->1 transition of pressed[i].
REQ-019 SHALL, in IDLE, set false_start[i] on each press event of channel i (sticky); arm SHALL NOT clear false_start.
REQ-020 SHALL, in IDLE on arm: enter ARMED, zero the timer and clear first_valid, first_id, react_time and timed_out.
REQ-021 SHALL, in ARMED, increment the 16-bit timer each cycle.
REQ-022 SHALL, in ARMED, ignore press events from channels whose false_start bit is set (lockout).
REQ-023 SHALL, in ARMED on any eligible press event, on that same edge: enter DONE, set first_valid = 1, load first_id with the event channel and load react_time with the pre-increment timer value.
REQ-024 SHALL, when several eligible press events occur in the same cycle, select the lowest channel index.
REQ-025 SHALL, in ARMED when the timer equals TIMEOUT with no eligible event that cycle, enter DONE with timed_out = 1 and first_valid = 0; an eligible event in the same cycle SHALL take priority.
REQ-026 SHALL hold all capture outputs in DONE and ignore arm and press events there, except that pressed keeps tracking.
REQ-027 SHALL, on clear in any state, enter IDLE and zero false_start, first_valid, first_id, react_time and timed_out; clear SHALL win over a simultaneous arm or press event.
REQ-028 SHALL ignore arm outside IDLE.
REQ-029 SHALL zero-extend first_id when NUM_PLAYERS < 8.

Reset
REQ-030 SHALL, while rst = 1, force state = IDLE and zero every output, the timer, the debounce counters and the synchronizers, independent of clk.
REQ-031 SHALL, when rst is asserted mid-round, discard the round with no capture; after release the block waits in IDLE.
REQ-032 SHALL, on rst release with a button held, treat the held button as a new press after the debounce delay (false start if still IDLE).

Verification (DEBOUNCE_CYCLES = 4, TIMEOUT = 100, NUM_PLAYERS = 4)
REQ-033 SHALL cover: arm; 10 cycles later btn_n[2] falls and holds -> DONE, first_id = 2, first_valid = 1, react_time = 16 (10 + 2 sync + 4 debounce).
REQ-034 SHALL cover: arm; btn_n[1] and btn_n[3] fall on the same edge -> first_id = 1.
REQ-035 SHALL cover: in IDLE, press player 0 -> false_start = 4'b0001; arm; press 0 and then 3 -> first_id = 3.
REQ-036 SHALL cover: a 2-cycle low glitch on btn_n[0] -> pressed stays 0 and no capture occurs.
REQ-037 SHALL cover: arm with no press -> DONE after 101 ARMED cycles, timed_out = 1, first_valid = 0; arm and press in DONE -> no change.
REQ-038 SHALL cover: rst or clear pulsed in ARMED -> IDLE with all outputs 0; clear and arm on the same cycle -> IDLE.
